// File: rtl/dmem_access_ctrl.sv
// MEM-stage sequencer for a single-port handshaked data memory: byte-lane alignment,
// misaligned accesses split into two word transactions, load extension and ack timeout.
module dmem_access_ctrl #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load_i,
   input  logic        store_i,
   input  logic [1:0]  width_i,
   input  logic        sign_ext_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        stall_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [29:0] mem_addr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_ack_i
);

   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    off_q, off_d;
   logic [1:0]    width_q, width_d;
   logic          sign_q, sign_d;
   logic          split_q, split_d;
   logic [3:0]    be_hi_q, be_hi_d;
   logic [31:0]   wdata_hi_q, wdata_hi_d;
   logic [31:0]   lo_q, lo_d;
   logic          req_d, we_d, err_d;
   logic [29:0]   addr_d;
   logic [3:0]    be_d;
   logic [31:0]   wdata_d, rdata_d;

   logic [3:0]    size_mask;
   logic [7:0]    m8;
   logic [63:0]   w64;

   // Shift the two captured words down to the access offset, then truncate and extend.
   function automatic logic [31:0] load_ext(input logic [63:0] raw, input logic [1:0] off,
                                            input logic [1:0] width, input logic sign);
      logic [31:0] r;
      r = 32'(raw >> {off, 3'b000});
      case (width)
         2'b00:   load_ext = sign ? {{24{r[7]}}, r[7:0]}   : {24'b0, r[7:0]};
         2'b01:   load_ext = sign ? {{16{r[15]}}, r[15:0]} : {16'b0, r[15:0]};
         default: load_ext = r;
      endcase
   endfunction

   always_comb begin
      case (width_i)
         2'b00:   size_mask = 4'b0001;
         2'b01:   size_mask = 4'b0011;
         default: size_mask = 4'b1111;
      endcase
      m8  = {4'b0, size_mask} << addr_i[1:0];
      w64 = {32'b0, wdata_i} << {addr_i[1:0], 3'b000};
   end

   assign stall_o = (load_i | store_i) && (state_q != DONE);

   // NOTE: every signal is given a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      off_d      = off_q;
      width_d    = width_q;
      sign_d     = sign_q;
      split_d    = split_q;
      be_hi_d    = be_hi_q;
      wdata_hi_d = wdata_hi_q;
      lo_d       = lo_q;
      req_d      = mem_req_o;
      we_d       = mem_we_o;
      addr_d     = mem_addr_o;
      be_d       = mem_be_o;
      wdata_d    = mem_wdata_o;
      rdata_d    = '0;
      err_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (load_i | store_i) begin
               state_d    = ACC0;
               cnt_d      = '0;
               off_d      = addr_i[1:0];
               width_d    = width_i;
               sign_d     = sign_ext_i;
               split_d    = |m8[7:4];
               be_hi_d    = m8[7:4];
               wdata_hi_d = store_i ? w64[63:32] : '0;
               req_d      = 1'b1;
               we_d       = store_i;
               addr_d     = addr_i[31:2];
               be_d       = m8[3:0];
               wdata_d    = store_i ? w64[31:0] : '0;
            end
         end
         ACC0, ACC1: begin
            if (mem_ack_i) begin
               if (state_q == ACC0 && split_q) begin
                  state_d = ACC1;
                  cnt_d   = '0;
                  lo_d    = mem_rdata_i;
                  addr_d  = mem_addr_o + 30'd1;
                  be_d    = be_hi_q;
                  wdata_d = wdata_hi_q;
               end else begin
                  state_d = DONE;
                  req_d   = 1'b0;
                  we_d    = 1'b0;
                  be_d    = '0;
                  wdata_d = '0;
                  if (!mem_we_o)
                     rdata_d = (state_q == ACC0)
                             ? load_ext({32'b0, mem_rdata_i}, off_q, width_q, sign_q)
                             : load_ext({mem_rdata_i, lo_q}, off_q, width_q, sign_q);
               end
            end else if (cnt_q == CNT_LAST) begin
               // Abort: any remaining split half is skipped.
               state_d = DONE;
               err_d   = 1'b1;
               req_d   = 1'b0;
               we_d    = 1'b0;
               be_d    = '0;
               wdata_d = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         off_q       <= '0;
         width_q     <= '0;
         sign_q      <= 1'b0;
         split_q     <= 1'b0;
         be_hi_q     <= '0;
         wdata_hi_q  <= '0;
         lo_q        <= '0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_be_o    <= '0;
         mem_wdata_o <= '0;
         rdata_o     <= '0;
         err_o       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         off_q       <= off_d;
         width_q     <= width_d;
         sign_q      <= sign_d;
         split_q     <= split_d;
         be_hi_q     <= be_hi_d;
         wdata_hi_q  <= wdata_hi_d;
         lo_q        <= lo_d;
         mem_req_o   <= req_d;
         mem_we_o    <= we_d;
         mem_addr_o  <= addr_d;
         mem_be_o    <= be_d;
         mem_wdata_o <= wdata_d;
         rdata_o     <= rdata_d;
         err_o       <= err_d;
      end
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: aligned/misaligned loads and stores, extension,
// timeout abort and asynchronous reset during a split access.
module tb_dmem_access_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        load_i = 1'b0, store_i = 1'b0, sign_ext_i = 1'b0;
   logic [1:0]  width_i = '0;
   logic [31:0] addr_i = '0, wdata_i = '0;
   logic        stall_o, err_o, mem_req_o, mem_we_o;
   logic [31:0] rdata_o, mem_wdata_o;
   logic [29:0] mem_addr_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_rdata_i = '0;
   logic        mem_ack_i = 1'b0;

   int total = 0;
   int bad   = 0;

   always #5 clk_i = ~clk_i;

   dmem_access_ctrl #(.TIMEOUT(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .load_i(load_i), .store_i(store_i),
      .width_i(width_i), .sign_ext_i(sign_ext_i), .addr_i(addr_i), .wdata_i(wdata_i),
      .stall_o(stall_o), .rdata_o(rdata_o), .err_o(err_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
      .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic issue(input logic ld, input logic st, input logic [1:0] w, input logic s,
                        input logic [31:0] a, input logic [31:0] d);
      load_i = ld; store_i = st; width_i = w; sign_ext_i = s; addr_i = a; wdata_i = d;
      #1;
   endtask

   task automatic release_bus();
      load_i = 1'b0; store_i = 1'b0; mem_ack_i = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] byte_exp [2];
      logic [31:0] half_exp [2];
      byte_exp[0] = 32'h0000_0080; byte_exp[1] = 32'hFFFF_FF80;
      half_exp[0] = 32'h0000_8811; half_exp[1] = 32'hFFFF_8811;

      // Reset state
      #12;
      check("rst_req",   {31'b0, mem_req_o}, 32'd0);
      check("rst_stall", {31'b0, stall_o},   32'd0);
      check("rst_rdata", rdata_o,            32'd0);
      check("rst_err",   {31'b0, err_o},     32'd0);
      check("rst_be",    {28'b0, mem_be_o},  32'd0);
      rst_i = 1'b1;
      tick();

      // Aligned word load, ack on first ACC0 cycle
      issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
      check("wl_stall_idle", {31'b0, stall_o}, 32'd1);
      tick();
      check("wl_req",   {31'b0, mem_req_o},  32'd1);
      check("wl_we",    {31'b0, mem_we_o},   32'd0);
      check("wl_addr",  {2'b0, mem_addr_o},  32'h40);
      check("wl_be",    {28'b0, mem_be_o},   32'hF);
      check("wl_stall_acc", {31'b0, stall_o}, 32'd1);
      mem_ack_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
      tick();
      check("wl_stall_done", {31'b0, stall_o}, 32'd0);
      check("wl_rdata", rdata_o, 32'hDEAD_BEEF);
      check("wl_err",   {31'b0, err_o}, 32'd0);
      check("wl_req_done", {31'b0, mem_req_o}, 32'd0);
      release_bus();
      tick();
      check("wl_rdata_idle", rdata_o, 32'd0);

      // Byte load at offset 3, zero- then sign-extended
      for (int s = 0; s < 2; s++) begin
         issue(1'b1, 1'b0, 2'b00, s[0], 32'h0000_0103, 32'h0);
         tick();
         check("bl_be",   {28'b0, mem_be_o},  32'h8);
         check("bl_addr", {2'b0, mem_addr_o}, 32'h40);
         mem_ack_i = 1'b1; mem_rdata_i = 32'h8011_2233;
         tick();
         check("bl_rdata", rdata_o, byte_exp[s]);
         release_bus();
         tick();
      end

      // Misaligned word store split across two words
      issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_01FE, 32'hAABB_CCDD);
      tick();
      check("ws0_we",    {31'b0, mem_we_o},  32'd1);
      check("ws0_addr",  {2'b0, mem_addr_o}, 32'h7F);
      check("ws0_be",    {28'b0, mem_be_o},  32'hC);
      check("ws0_wdata", mem_wdata_o,        32'hCCDD_0000);
      mem_ack_i = 1'b1;
      tick();
      check("ws1_req",   {31'b0, mem_req_o}, 32'd1);
      check("ws1_addr",  {2'b0, mem_addr_o}, 32'h80);
      check("ws1_be",    {28'b0, mem_be_o},  32'h3);
      check("ws1_wdata", mem_wdata_o,        32'h0000_AABB);
      check("ws1_stall", {31'b0, stall_o},   32'd1);
      tick();
      check("ws_done_stall", {31'b0, stall_o}, 32'd0);
      check("ws_done_rdata", rdata_o,          32'd0);
      release_bus();
      tick();

      // Misaligned half load at 0x7, zero- then sign-extended
      for (int s = 0; s < 2; s++) begin
         issue(1'b1, 1'b0, 2'b01, s[0], 32'h0000_0007, 32'h0);
         tick();
         check("hl0_addr", {2'b0, mem_addr_o}, 32'h1);
         check("hl0_be",   {28'b0, mem_be_o},  32'h8);
         mem_ack_i = 1'b1; mem_rdata_i = 32'h1122_3344;
         tick();
         check("hl1_addr", {2'b0, mem_addr_o}, 32'h2);
         check("hl1_be",   {28'b0, mem_be_o},  32'h1);
         mem_rdata_i = 32'h5566_7788;
         tick();
         check("hl_rdata", rdata_o, half_exp[s]);
         release_bus();
         tick();
      end

      // Timeout: never ack, req held for exactly TIMEOUT cycles
      issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("to_req", {31'b0, mem_req_o}, 32'd1);
      end
      tick();
      check("to_req_drop", {31'b0, mem_req_o}, 32'd0);
      check("to_err",      {31'b0, err_o},     32'd1);
      check("to_rdata",    rdata_o,            32'd0);
      check("to_stall",    {31'b0, stall_o},   32'd0);
      release_bus();
      tick();
      check("to_err_idle", {31'b0, err_o},     32'd0);
      check("to_req_idle", {31'b0, mem_req_o}, 32'd0);

      // Ack with no request outstanding is ignored
      mem_ack_i = 1'b1;
      tick();
      check("stray_ack_req",   {31'b0, mem_req_o}, 32'd0);
      check("stray_ack_stall", {31'b0, stall_o},   32'd0);
      mem_ack_i = 1'b0;
      tick();

      // Reset during a split load's ACC1 with the ack delayed, then restart
      issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0007, 32'h0);
      tick();
      mem_ack_i = 1'b1; mem_rdata_i = 32'h1122_3344;
      tick();
      mem_ack_i = 1'b0;
      check("rm_acc1_addr", {2'b0, mem_addr_o}, 32'h2);
      #2 rst_i = 1'b0;
      #1;
      check("rm_req",   {31'b0, mem_req_o}, 32'd0);
      check("rm_stall", {31'b0, stall_o},   32'd1);
      check("rm_be",    {28'b0, mem_be_o},  32'd0);
      #2 rst_i = 1'b1;
      tick();
      check("rs_req",  {31'b0, mem_req_o}, 32'd1);
      check("rs_addr", {2'b0, mem_addr_o}, 32'h1);
      check("rs_be",   {28'b0, mem_be_o},  32'h8);
      mem_ack_i = 1'b1; mem_rdata_i = 32'h1122_3344;
      tick();
      mem_ack_i = 1'b0;
      check("rs_acc1_addr", {2'b0, mem_addr_o}, 32'h2);
      tick();
      check("rs_wait_req",   {31'b0, mem_req_o}, 32'd1);
      check("rs_wait_stall", {31'b0, stall_o},   32'd1);
      check("rs_wait_addr",  {2'b0, mem_addr_o}, 32'h2);
      mem_ack_i = 1'b1; mem_rdata_i = 32'h5566_7788;
      tick();
      check("rs_rdata", rdata_o, 32'h0000_8811);
      check("rs_stall_done", {31'b0, stall_o}, 32'd0);
      release_bus();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
